eco32f_cache_refill: RTL and testbench

- Refill/flush controller directly upstream of the eco32f cache tag/data RAMs; sole driver of the cache write port (write address, write data, write enable, invalidate).
- On a core-signalled miss, fetches one 32-byte line (8 words) over a Wishbone B3 master port as a critical-word-first wrapping burst, writing each word into the cache and forwarding the critical word early.
- Also sweeps all 128 sets with invalidating writes on a flush request.
- One instance per cache (icache and dcache).

---
 rtl/eco32f_cache_refill_if.sv | 29 ++
 rtl/eco32f_cache_refill.sv | 211 +++++++++++++++++++++
 tb/tb_eco32f_cache_refill.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eco32f_cache_refill_if.sv
// Wishbone B3 read-burst port between the eco32f cache refill controller
// and the memory bus.
//
// Handshake: the master holds cyc and stb high, with a stable adr/cti/bte,
// for every beat of a burst. A beat completes in the cycle where the slave
// drives ack (data valid on dat_i) or err (beat failed, burst abandoned).
// A cycle with neither ack nor err is a wait state and nothing advances.
interface eco32f_cache_refill_if;
  logic [31:0] wbm_adr_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/eco32f_cache_refill.sv
// eco32f cache refill / flush controller.
// Fetches one cache line as a critical-word-first wrapping Wishbone burst,
// writing each beat into the cache one cycle after its ack, and sweeps all
// sets with invalidating writes on a flush request. It is the only driver
// of the cache write port.
module eco32f_cache_refill #(
  parameter int LINE_WORDS_LOG2 = 3,
  parameter int INDEX_WIDTH     = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refill_req,
  input  logic [31:0] refill_addr,
  input  logic        flush_req,
  output logic        refill_busy,
  output logic        refill_done,
  output logic        refill_err,
  output logic        crit_valid,
  output logic [31:0] crit_data,
  output logic        flush_done,
  output logic [31:0] cache_waddr,
  output logic [31:0] cache_wdata,
  output logic        cache_we,
  output logic        cache_invalidate,
  output logic [2:0]  state_dbg,
  eco32f_cache_refill_if.master wbm
);

  // Byte-offset bits inside a line, line-address bits above them, and the
  // zero bits above the set index in a flush address.
  localparam int OFF_W = LINE_WORDS_LOG2 + 2;
  localparam int TAG_W = 32 - OFF_W;
  localparam int HI_W  = 32 - INDEX_WIDTH - OFF_W;

  localparam logic [LINE_WORDS_LOG2-1:0] LAST_BEAT  = '1;
  localparam logic [INDEX_WIDTH-1:0]     LAST_INDEX = '1;

  // DRAIN is the cycle after the final ack: bus released, last beat written.
  // INVAL is the cycle after a bus error: the whole line is marked invalid.
  // FDONE carries the flush_done pulse.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REFILL = 3'd1,
    S_DRAIN  = 3'd2,
    S_INVAL  = 3'd3,
    S_DONE   = 3'd4,
    S_FLUSH  = 3'd5,
    S_FDONE  = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  logic [TAG_W-1:0]           line_q;      // line address of the miss
  logic [LINE_WORDS_LOG2-1:0] off_q;       // word offset of the current beat
  logic [LINE_WORDS_LOG2-1:0] beat_q;      // beats acked so far
  logic [INDEX_WIDTH-1:0]     idx_q;       // flush sweep set index
  logic                       err_q;       // refill aborted by bus error
  logic                       wr_pend_q;   // acked beat waiting to be written
  logic                       crit_pend_q; // the pending beat is the critical word
  logic [31:0]                wr_addr_q;
  logic [31:0]                wr_data_q;
  logic [31:0]                crit_q;
  logic [31:0]                bus_addr;
  logic                       beat_ok;
  logic                       beat_err;

  // The byte position inside the missing word does not affect a line fill.
  logic unused_addr_bits;
  assign unused_addr_bits = ^refill_addr[1:0];

  // Word address of the current beat: offset wraps inside the line.
  assign bus_addr = {line_q, off_q, 2'b00};

  // ack and err are exclusive on the bus; err wins if both ever appear.
  assign beat_err = (state == S_REFILL) && wbm.wbm_err_i;
  assign beat_ok  = (state == S_REFILL) && wbm.wbm_ack_i && !wbm.wbm_err_i;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; flush has priority over a simultaneous refill.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (flush_req) begin
          state_next = S_FLUSH;
        end else if (refill_req) begin
          state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        if (beat_err) begin
          state_next = S_INVAL;
        end else if (beat_ok && (beat_q == LAST_BEAT)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: state_next = S_DONE;
      S_INVAL: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_FLUSH: begin
        if (idx_q == LAST_INDEX) begin
          state_next = S_FDONE;
        end
      end
      S_FDONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Miss address capture, beat/offset counters and flush index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      off_q  <= '0;
      beat_q <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          beat_q <= '0;
          idx_q  <= '0;
          err_q  <= 1'b0;
          if (!flush_req && refill_req) begin
            line_q <= refill_addr[31:OFF_W];
            off_q  <= refill_addr[OFF_W-1:2];
          end
        end
        S_REFILL: begin
          if (beat_err) begin
            err_q <= 1'b1;
          end else if (beat_ok) begin
            off_q  <= off_q + 1'b1;
            beat_q <= beat_q + 1'b1;
          end
        end
        S_FLUSH: idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Registered cache write of each acked beat; beat 0 is the critical word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_pend_q   <= 1'b0;
      crit_pend_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      crit_q      <= '0;
    end else begin
      wr_pend_q   <= beat_ok;
      crit_pend_q <= beat_ok && (beat_q == '0);
      if (beat_ok) begin
        wr_addr_q <= bus_addr;
        wr_data_q <= wbm.wbm_dat_i;
      end
      if (beat_ok && (beat_q == '0)) begin
        crit_q <= wbm.wbm_dat_i;
      end
    end
  end

  // Bus, cache-port and status outputs, decoded from registers only.
  always_comb begin
    wbm.wbm_cyc_o    = (state == S_REFILL);
    wbm.wbm_stb_o    = (state == S_REFILL);
    wbm.wbm_we_o     = 1'b0;
    wbm.wbm_sel_o    = 4'hf;
    wbm.wbm_bte_o    = 2'b10;
    wbm.wbm_cti_o    = 3'b000;
    wbm.wbm_adr_o    = '0;
    cache_we         = wr_pend_q;
    cache_invalidate = 1'b0;
    cache_waddr      = wr_addr_q;
    cache_wdata      = wr_data_q;
    if (state == S_REFILL) begin
      wbm.wbm_adr_o = bus_addr;
      wbm.wbm_cti_o = (beat_q == LAST_BEAT) ? 3'b111 : 3'b010;
    end
    if (state == S_INVAL) begin
      cache_we         = 1'b1;
      cache_invalidate = 1'b1;
      cache_waddr      = {line_q, {OFF_W{1'b0}}};
      cache_wdata      = '0;
    end
    if (state == S_FLUSH) begin
      cache_we         = 1'b1;
      cache_invalidate = 1'b1;
      cache_waddr      = {{HI_W{1'b0}}, idx_q, {OFF_W{1'b0}}};
      cache_wdata      = '0;
    end
    refill_busy = (state == S_REFILL) || (state == S_DRAIN) || (state == S_INVAL);
    refill_done = (state == S_DONE);
    refill_err  = (state == S_DONE) && err_q;
    flush_done  = (state == S_FDONE);
    crit_valid  = crit_pend_q;
    crit_data   = crit_q;
    state_dbg   = state;
  end

endmodule

// File: tb/tb_eco32f_cache_refill.sv
// Self-checking bench for eco32f_cache_refill: directed refill, stall,
// bus-error, flush and mid-burst reset scenarios plus randomized refills.
module tb_eco32f_cache_refill;

  localparam int W = 65;  // {invalidate, address[31:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        refill_req = 1'b0;
  logic [31:0] refill_addr = '0;
  logic        flush_req = 1'b0;
  logic        refill_busy, refill_done, refill_err, crit_valid, flush_done;
  logic [31:0] crit_data, cache_waddr, cache_wdata;
  logic        cache_we, cache_invalidate;
  logic [2:0]  state_dbg;

  eco32f_cache_refill_if wb ();

  eco32f_cache_refill dut (
    .clk(clk), .rst(rst),
    .refill_req(refill_req), .refill_addr(refill_addr), .flush_req(flush_req),
    .refill_busy(refill_busy), .refill_done(refill_done), .refill_err(refill_err),
    .crit_valid(crit_valid), .crit_data(crit_data), .flush_done(flush_done),
    .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .cache_we(cache_we), .cache_invalidate(cache_invalidate),
    .state_dbg(state_dbg),
    .wbm(wb)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [W-1:0] exp_q[$];
  bit          mon_en = 1'b1;
  logic [31:0] seed;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- helpers / reference model ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address of beat k of a wrapping, critical-word-first line fill.
  function automatic logic [31:0] word_addr(input logic [31:0] a, input int k);
    return (a & 32'hffff_ffe0) | ((((a >> 2) + k) % 8) << 2);
  endfunction

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] adr);
    return (adr * 32'h9e37_79b1) ^ seed;
  endfunction

  // ---------------- scoreboard: cache write port ----------------
  always @(negedge clk) begin
    if (rst && mon_en && cache_we) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected_we", cache_we, 1'b0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("wr_inval", cache_invalidate, e[64]);
        chk("wr_addr", cache_waddr, e[63:32]);
        if (!e[64]) chk("wr_data", cache_wdata, e[31:0]);
      end
    end
  end

  // ---------------- driver: one refill with slave responses ----------------
  // Called at #1 after a posedge with the DUT idle. stall_beat is held off
  // for stall_len cycles; err_beat (0..7) ends the burst with a bus error.
  task automatic do_refill(input logic [31:0] a, input int stall_beat, input int stall_len,
                           input int err_beat, output int done_c);
    int beat = 0, stall = 0, end_c = -1, first_c = -1, prev = 0, nxt;
    bit err_sent = 0, finished = 0, exp_cyc, exp_done;
    logic [31:0] wa;
    done_c = -1;
    refill_req = 1'b1;
    refill_addr = a;
    @(posedge clk); #1;
    for (int c = 0; c < 100 && !finished; c++) begin
      exp_cyc  = (end_c < 0);
      exp_done = (end_c >= 0) && (c == end_c + 2);
      chk("cyc", wb.wbm_cyc_o, exp_cyc);
      chk("stb", wb.wbm_stb_o, exp_cyc);
      chk("busy", refill_busy, exp_cyc || (c < end_c + 2));
      chk("done", refill_done, exp_done);
      chk("err", refill_err, exp_done && err_sent);
      chk("we", cache_we, prev != 0);
      chk("inval", cache_invalidate, prev == 2);
      chk("crit_valid", crit_valid, (first_c >= 0) && (c == first_c + 1));
      if ((first_c >= 0) && (c == first_c + 1)) chk("crit_data", crit_data, mem_word(word_addr(a, 0)));
      if (refill_done) done_c = c;
      nxt = 0;
      wb.wbm_ack_i = 1'b0;
      wb.wbm_err_i = 1'b0;
      if (exp_cyc) begin
        wa = word_addr(a, beat);
        chk("adr", wb.wbm_adr_o, wa);
        chk("cti", wb.wbm_cti_o, (beat == 7) ? 3'b111 : 3'b010);
        if (beat == err_beat) begin
          wb.wbm_err_i = 1'b1;
          err_sent = 1;
          end_c = c;
          nxt = 2;
          exp_q.push_back({1'b1, a & 32'hffff_ffe0, 32'h0});
        end else if (beat == stall_beat && stall < stall_len) begin
          stall++;
        end else begin
          wb.wbm_ack_i = 1'b1;
          wb.wbm_dat_i = mem_word(wa);
          exp_q.push_back({1'b0, wa, mem_word(wa)});
          if (beat == 0) first_c = c;
          if (beat == 7) end_c = c;
          beat++;
          nxt = 1;
        end
      end
      if (exp_done) begin
        refill_req = 1'b0;
        finished = 1;
      end
      prev = nxt;
      @(posedge clk); #1;
    end
    chk("refill_finished", finished, 1'b1);
    refill_req = 1'b0;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_err_i = 1'b0;
    chk("wr_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Flush raised together with a refill; the refill is left pending.
  task automatic do_flush(input logic [31:0] a);
    flush_req = 1'b1;
    refill_req = 1'b1;
    refill_addr = a;
    @(posedge clk); #1;
    for (int f = 0; f < 128; f++) begin
      exp_q.push_back({1'b1, 32'(f * 32), 32'h0});
      chk("flush_we", cache_we, 1'b1);
      chk("flush_inval", cache_invalidate, 1'b1);
      chk("flush_cyc", wb.wbm_cyc_o, 1'b0);
      chk("flush_busy", refill_busy, 1'b0);
      chk("flush_done_early", flush_done, 1'b0);
      @(posedge clk); #1;
    end
    chk("flush_done", flush_done, 1'b1);
    chk("flush_done_we", cache_we, 1'b0);
    flush_req = 1'b0;
    @(posedge clk); #1;
    chk("flush_done_pulse", flush_done, 1'b0);
    chk("flush_idle_cyc", wb.wbm_cyc_o, 1'b0);
    chk("flush_wr_missing", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    logic [31:0] a;
    seed = $urandom;
    wb.wbm_dat_i = '0;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_err_i = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    $display("info: state code held in reset = %0d", state_dbg);
    chk("rst_cyc", wb.wbm_cyc_o, 1'b0);
    chk("rst_stb", wb.wbm_stb_o, 1'b0);
    chk("rst_we_o", wb.wbm_we_o, 1'b0);
    chk("rst_sel", wb.wbm_sel_o, 4'hf);
    chk("rst_bte", wb.wbm_bte_o, 2'b10);
    chk("rst_cti", wb.wbm_cti_o, 3'b000);
    chk("rst_adr", wb.wbm_adr_o, 32'h0);
    chk("rst_cache_we", cache_we, 1'b0);
    chk("rst_cache_inval", cache_invalidate, 1'b0);
    chk("rst_waddr", cache_waddr, 32'h0);
    chk("rst_wdata", cache_wdata, 32'h0);
    chk("rst_busy", refill_busy, 1'b0);
    chk("rst_done", refill_done, 1'b0);
    chk("rst_err", refill_err, 1'b0);
    chk("rst_crit_valid", crit_valid, 1'b0);
    chk("rst_crit_data", crit_data, 32'h0);
    chk("rst_flush_done", flush_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // zero-wait refill; done in the 10th cycle counting bus start as the 1st
    do_refill(32'h0000_1234, 99, 0, 99, dc);
    chk("done_latency", dc, 9);

    // ack stalled 3 cycles on beat 4
    do_refill(32'h0000_1234, 4, 3, 99, dc);

    // bus error on beat 3
    do_refill(32'h0000_4000, 99, 0, 3, dc);
    chk("err_cyc_low", wb.wbm_cyc_o, 1'b0);

    // flush wins over a simultaneous refill, which then runs
    do_flush(32'h0000_8a6c);
    do_refill(32'h0000_8a6c, 99, 0, 99, dc);

    // asynchronous reset at beat 5 of a refill
    mon_en = 1'b0;
    a = 32'h0000_2a48;
    refill_req = 1'b1;
    refill_addr = a;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("rst_mid_adr", wb.wbm_adr_o, word_addr(a, k));
      wb.wbm_ack_i = 1'b1;
      wb.wbm_dat_i = mem_word(word_addr(a, k));
      @(posedge clk); #1;
    end
    wb.wbm_ack_i = 1'b0;
    chk("rst_mid_pre_cyc", wb.wbm_cyc_o, 1'b1);
    chk("rst_mid_pre_we", cache_we, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_cyc", wb.wbm_cyc_o, 1'b0);
    chk("rst_mid_stb", wb.wbm_stb_o, 1'b0);
    chk("rst_mid_cache_we", cache_we, 1'b0);
    chk("rst_mid_busy", refill_busy, 1'b0);
    chk("rst_mid_cti", wb.wbm_cti_o, 3'b000);
    refill_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_cyc", wb.wbm_cyc_o, 1'b0);
    chk("rst_rel_busy", refill_busy, 1'b0);
    mon_en = 1'b1;
    exp_q.delete();
    do_refill(32'h0000_2a48, 99, 0, 99, dc);

    // randomized refills
    for (int r = 0; r < 6; r++) begin
      int sb, sl, eb;
      a  = $urandom;
      sb = $urandom_range(0, 7);
      sl = $urandom_range(0, 4);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 99;
      do_refill(a, sb, sl, eb, dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
